// File: rtl/jtframe_sdram_pkg.sv
// Shared definitions for the romrq-to-SDRAM arbiter: FSM encoding,
// SDRAM word-address width and the slot-index width helper.
package jtframe_sdram_pkg;

    localparam int JTFRAME_SDRAM_AW = 22;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DELIVER   = 2'd3
    } arb_state_t;

    // Bits needed to hold a slot index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin priority encoder: returns the first
// requesting slot strictly after 'last', wrapping modulo SLOTS.
module jtframe_rr_pick
    import jtframe_sdram_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int IW    = idx_width(SLOTS)
) (
    input  logic [SLOTS-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    winner,
    output logic             valid
);

    int          idx;
    logic [IW-1:0] idx_v;

    // Scan slots last+1 .. last+SLOTS; the first hit wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        idx_v  = '0;
        for (int k = 1; k <= SLOTS; k++) begin
            idx   = (int'(last) + k) % SLOTS;
            idx_v = IW'(idx);
            if (!valid && req[idx_v]) begin
                valid  = 1'b1;
                winner = idx_v;
            end
        end
    end

endmodule

// File: rtl/jtframe_romrq_arb.sv
// Round-robin arbiter connecting several romrq slots to one SDRAM read
// port. One read is outstanding at a time; the returned word is broadcast
// and qualified by the one-hot slot_we plus a one-cycle slot_din_ok.
module jtframe_romrq_arb
    import jtframe_sdram_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = JTFRAME_SDRAM_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_we,
    output logic [31:0]         slot_din,
    output logic                slot_din_ok,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [31:0]         data_read
);

    localparam int IW = idx_width(SLOTS);

    arb_state_t     state_reg;
    logic [IW-1:0]  last_reg;
    logic [IW-1:0]  win_reg;
    logic [AW-1:0]  addr_reg;

    logic [IW-1:0]  pick_idx;
    logic           pick_valid;
    logic [SLOTS-1:0] pick_onehot;
    logic [AW-1:0]  addr_arr [SLOTS];
    logic [AW-1:0]  pick_addr;
    logic [AW-1:0]  cur_addr;
    logic           data_match;

    // Unpack per-slot addresses and build the one-hot grant of the pick.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign addr_arr[gi]    = slot_addr[gi*AW +: AW];
            assign pick_onehot[gi] = (pick_idx == IW'(gi));
        end
    endgenerate

    assign pick_addr  = addr_arr[pick_idx];
    assign cur_addr   = addr_arr[win_reg];
    // A slot that moved address while its read was in flight gets nothing.
    assign data_match = (cur_addr == addr_reg);

    jtframe_rr_pick #(
        .SLOTS (SLOTS),
        .IW    (IW)
    ) u_pick (
        .req    (slot_req),
        .last   (last_reg),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // Grant / request / deliver sequencing; all outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            last_reg    <= IW'(SLOTS - 1);
            win_reg     <= '0;
            addr_reg    <= '0;
            slot_we     <= '0;
            slot_din    <= '0;
            slot_din_ok <= 1'b0;
            sdram_req   <= 1'b0;
            sdram_addr  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    slot_din_ok <= 1'b0;
                    if (pick_valid) begin
                        win_reg    <= pick_idx;
                        last_reg   <= pick_idx;
                        addr_reg   <= pick_addr;
                        sdram_addr <= pick_addr;
                        slot_we    <= pick_onehot;
                        sdram_req  <= 1'b1;
                        state_reg  <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (data_rdy) begin
                            slot_din <= data_read;
                            if (data_match) begin
                                slot_din_ok <= 1'b1;
                                state_reg   <= ST_DELIVER;
                            end else begin
                                slot_we   <= '0;
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            state_reg <= ST_WAIT_DATA;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (data_rdy) begin
                        slot_din <= data_read;
                        if (data_match) begin
                            slot_din_ok <= 1'b1;
                            state_reg   <= ST_DELIVER;
                        end else begin
                            slot_we   <= '0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_DELIVER: begin
                    slot_we     <= '0;
                    slot_din_ok <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// Directed bench for jtframe_romrq_arb: single access, round-robin order,
// address change mid-flight, simultaneous ack+data, reset mid-flight and
// spurious controller strobes.
module tb_jtframe_romrq_arb;

    localparam int SLOTS = 4;
    localparam int AW    = 22;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_we;
    logic [31:0]         slot_din;
    logic                slot_din_ok;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack;
    logic                data_rdy;
    logic [31:0]         data_read;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtframe_romrq_arb #(.SLOTS(SLOTS), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slot_req    (slot_req),
        .slot_addr   (slot_addr),
        .slot_we     (slot_we),
        .slot_din    (slot_din),
        .slot_din_ok (slot_din_ok),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; slot_req = '0; slot_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        tick(); tick();
        rst_n = 1'b1;
        checks++;
        if ({slot_we, slot_din_ok, sdram_req} !== 6'b0 || slot_din !== 32'h0 || sdram_addr !== 22'h0) begin
            errors++;
            $display("FAIL reset_outputs we=%b ok=%b req=%b din=%h addr=%h required all zero",
                     slot_we, slot_din_ok, sdram_req, slot_din, sdram_addr);
        end
        $display("txn reset done");
    endtask

    task automatic test_single();
        do_reset();
        slot_addr[2*AW +: AW] = 22'h01234;
        slot_req = 4'b0100;
        tick();
        slot_req = 4'b0000;
        checks++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h01234) begin
            errors++;
            $display("FAIL single_req req=%b addr=%h required 1 01234", sdram_req, sdram_addr);
        end
        checks++;
        if (slot_we !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant we=%b required 0100", slot_we);
        end
        tick(); tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        checks++;
        if (sdram_req !== 1'b0 || slot_we !== 4'b0100) begin
            errors++;
            $display("FAIL single_ack req=%b we=%b required 0 0100", sdram_req, slot_we);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (slot_din_ok !== 1'b0) begin
            errors++;
            $display("FAIL single_early_ok ok=%b required 0", slot_din_ok);
        end
        data_rdy = 1'b1; data_read = 32'hDEADBEEF;
        tick();
        data_rdy = 1'b0;
        checks++;
        if (slot_din !== 32'hDEADBEEF || slot_din_ok !== 1'b1 || slot_we !== 4'b0100) begin
            errors++;
            $display("FAIL single_data din=%h ok=%b we=%b required deadbeef 1 0100",
                     slot_din, slot_din_ok, slot_we);
        end
        tick();
        checks++;
        if (slot_din_ok !== 1'b0 || slot_we !== 4'b0000) begin
            errors++;
            $display("FAIL single_release ok=%b we=%b required 0 0000", slot_din_ok, slot_we);
        end
        $display("txn single slot2 addr=%h data=%h", 22'h01234, 32'hDEADBEEF);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_order [6];
        logic       ok;
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b1000;
        exp_order[3] = 4'b0001; exp_order[4] = 4'b0010; exp_order[5] = 4'b1000;
        do_reset();
        slot_addr[0*AW +: AW] = 22'h00010;
        slot_addr[1*AW +: AW] = 22'h00020;
        slot_addr[3*AW +: AW] = 22'h00030;
        slot_req = 4'b1011;
        for (int n = 0; n < 6; n++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (slot_we !== 4'b0000) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            checks++;
            if (!ok || slot_we !== exp_order[n]) begin
                errors++;
                $display("FAIL rr_grant%0d we=%b required %b", n, slot_we, exp_order[n]);
            end
            $display("txn rr grant%0d we=%b addr=%h", n, slot_we, sdram_addr);
            sdram_ack = 1'b1;
            tick();
            sdram_ack = 1'b0;
            data_rdy = 1'b1; data_read = 32'h1000 + n;
            tick();
            data_rdy = 1'b0;
            tick();
        end
        slot_req = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_addr_change();
        do_reset();
        slot_addr[1*AW +: AW] = 22'h00100;
        slot_req = 4'b0010;
        tick();
        checks++;
        if (slot_we !== 4'b0010 || sdram_addr !== 22'h00100) begin
            errors++;
            $display("FAIL chg_grant we=%b addr=%h required 0010 00100", slot_we, sdram_addr);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        slot_addr[1*AW +: AW] = 22'h00200;
        data_rdy = 1'b1; data_read = 32'h0BAD0BAD;
        tick();
        data_rdy = 1'b0;
        checks++;
        if (slot_din_ok !== 1'b0 || slot_we !== 4'b0000) begin
            errors++;
            $display("FAIL chg_discard ok=%b we=%b required 0 0000", slot_din_ok, slot_we);
        end
        tick();
        checks++;
        if (slot_we !== 4'b0010 || sdram_addr !== 22'h00200 || sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL chg_regrant we=%b addr=%h req=%b required 0010 00200 1",
                     slot_we, sdram_addr, sdram_req);
        end
        slot_req = 4'b0000;
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b1; data_read = 32'h00C0FFEE;
        tick();
        data_rdy = 1'b0;
        checks++;
        if (slot_din_ok !== 1'b1 || slot_din !== 32'h00C0FFEE) begin
            errors++;
            $display("FAIL chg_deliver ok=%b din=%h required 1 00c0ffee", slot_din_ok, slot_din);
        end
        tick();
        $display("txn addr change slot1 00100->00200 delivered");
    endtask

    task automatic test_ack_data();
        do_reset();
        slot_addr[0*AW +: AW] = 22'h003FF;
        slot_req = 4'b0001;
        tick();
        slot_req = 4'b0000;
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h55AA55AA;
        tick();
        sdram_ack = 1'b0; data_rdy = 1'b0;
        checks++;
        if (slot_din_ok !== 1'b1 || slot_din !== 32'h55AA55AA || sdram_req !== 1'b0 || slot_we !== 4'b0001) begin
            errors++;
            $display("FAIL ackdata_deliver ok=%b din=%h req=%b we=%b required 1 55aa55aa 0 0001",
                     slot_din_ok, slot_din, sdram_req, slot_we);
        end
        tick();
        checks++;
        if (slot_din_ok !== 1'b0 || slot_we !== 4'b0000) begin
            errors++;
            $display("FAIL ackdata_release ok=%b we=%b required 0 0000", slot_din_ok, slot_we);
        end
        $display("txn ack+data slot0 data=%h", 32'h55AA55AA);
    endtask

    task automatic test_reset_mid();
        do_reset();
        slot_addr[0*AW +: AW] = 22'h00ABC;
        slot_req = 4'b0001;
        tick();
        slot_req = 4'b0000;
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({slot_we, slot_din_ok, sdram_req} !== 6'b0 || slot_din !== 32'h0 || sdram_addr !== 22'h0) begin
            errors++;
            $display("FAIL midrst_outputs we=%b ok=%b req=%b din=%h addr=%h required all zero",
                     slot_we, slot_din_ok, sdram_req, slot_din, sdram_addr);
        end
        data_rdy = 1'b1; data_read = 32'h12345678;
        tick();
        data_rdy = 1'b0;
        checks++;
        if (slot_din_ok !== 1'b0 || slot_din !== 32'h0 || slot_we !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_stray ok=%b din=%h we=%b required 0 0 0000",
                     slot_din_ok, slot_din, slot_we);
        end
        $display("txn reset mid-flight");
    endtask

    task automatic test_spurious();
        do_reset();
        slot_req = 4'b0000;
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        checks++;
        if ({slot_we, slot_din_ok, sdram_req} !== 6'b0) begin
            errors++;
            $display("FAIL spur_ack we=%b ok=%b req=%b required 0", slot_we, slot_din_ok, sdram_req);
        end
        data_rdy = 1'b1; data_read = 32'hFFFFFFFF;
        tick();
        data_rdy = 1'b0;
        tick();
        checks++;
        if ({slot_we, slot_din_ok, sdram_req} !== 6'b0 || slot_din !== 32'h0) begin
            errors++;
            $display("FAIL spur_data we=%b ok=%b req=%b din=%h required 0",
                     slot_we, slot_din_ok, sdram_req, slot_din);
        end
        $display("txn spurious strobes");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_addr_change();
        test_ack_data();
        test_reset_mid();
        test_spurious();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
